kamikaze_mem_arbiter: RTL and testbench
=======================================

Name: kamikaze_mem_arbiter

Overview:
- Shares one 32-bit memory port between instruction fetch (read-only) and load/store (read/write) in the kamikaze RV32IMC core.
- Sits between the kamikaze_fetch / LSU request interfaces and the external unified memory bus.
- Issues one outstanding transaction at a time through a registered request stage and a 3-state FSM.
- Data port has priority; a streak counter prevents fetch starvation.

Parameters:
- MAX_LS_STREAK, 4: max consecutive contested LSU grants before fetch is forced; legal range 1..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o
- if_addr_i  in  32  fetch word address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- ls_req_i  in  1  LSU request; held with all ls_* fields until ls_gnt_o
- ls_we_i  in  1  1 = write
- ls_be_i  in  4  byte enables
- ls_addr_i  in  32  LSU address
- ls_wdata_i  in  32  write data
- ls_gnt_o  out  1  LSU request accepted (1-cycle pulse)
- ls_rvalid_o  out  1  LSU response valid (reads and writes)
- ls_rdata_o  out  32  LSU read data
- mem_req_o, mem_we_o  out  1 each  memory request and write enable, registered
- mem_be_o  out  4  registered
- mem_addr_o, mem_wdata_o  out  32 each  registered
- mem_gnt_i  in  1  memory accepted mem_req_o this cycle
- mem_rvalid_i  in  1  response valid; earliest the cycle after mem_gnt_i
- mem_rdata_i  in  32  response data
- busy_o  out  1  state != IDLE

Behaviour:
- FSM states:
  - IDLE: no transaction.
  - REQ: mem_req_o high, waiting for mem_gnt_i.
  - RESP: waiting for mem_rvalid_i.
  - An owner flag (IF or LS) is latched with each accepted request.
- Reset (rst_i==0 at a clock edge):
  - state IDLE, owner IF, streak 0.
  - mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o all 0.
- Accept opportunity:
  - Occurs in IDLE, or in RESP in the cycle mem_rvalid_i==1.
  - If any request is present, exactly one gnt_o is driven combinationally in that cycle.
  - Next edge: the request fields are registered onto mem_*, owner is latched, state goes to REQ.
  - With no request, RESP+rvalid goes to IDLE.
- Arbitration:
  - Only ls_req_i: grant LS.
  - Only if_req_i: grant IF.
  - Both requesting: grant LS unless streak==MAX_LS_STREAK, in which case grant IF.
- Streak counter:
  - Increments on an LS grant with if_req_i high.
  - Clears on any IF grant and on an LS grant with if_req_i low.
  - Saturates at MAX_LS_STREAK.
- Fetch transaction fields: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- REQ state:
  - mem_* held stable until mem_gnt_i.
  - On mem_gnt_i: next edge clears mem_req_o and moves to RESP.
  - mem_rvalid_i is ignored in REQ.
- RESP state:
  - mem_rvalid_i routes combinationally to the owner's rvalid_o; the other rvalid_o stays 0.
  - if_rdata_o and ls_rdata_o both equal mem_rdata_i at all times; they are qualified only by the respective rvalid.
- mem_rvalid_i in IDLE is dropped; it does not reach either port.
- Minimum latency: gnt_o in cycle N, mem_req_o in N+1; if mem_gnt_i is in N+1, rvalid_o can appear in N+2.
- Back-to-back throughput: one transaction per 2 cycles.
- Reset mid-transaction: the transaction is abandoned, no rvalid_o is produced, and mem_req_o is 0 the cycle after the reset edge.
- A requester that drops req before gnt is legal; nothing is issued for it.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x100, mem_gnt_i immediate, mem_rvalid_i next cycle with rdata=0x00000013 -> if_gnt_o at N; mem_req_o=1, mem_addr_o=0x100, mem_be_o=F, mem_we_o=0 at N+1; if_rvalid_o=1, if_rdata_o=0x13 at N+2; ls_rvalid_o=0 throughout.
- Store: ls_we_i=1, ls_be_i=4'b0011, ls_addr_i=0x2000, ls_wdata_i=0xDEADBEEF; mem_gnt_i delayed 3 cycles -> mem fields stable for all 3 REQ cycles; ls_rvalid_o on the response; if_gnt_o never asserted.
- Contention, MAX_LS_STREAK=4: both requesting continuously -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Back-to-back: a new ls request is present in the rvalid cycle -> ls_gnt_o in that same cycle; mem_req_o high the next cycle with no IDLE gap.
- Reset mid-op: rst_i=0 during RESP, then mem_rvalid_i=1 after release -> no rvalid_o on either port; busy_o=0; all mem_* outputs 0.
- Stray response: mem_rvalid_i=1 while IDLE or REQ -> both rvalid_o stay 0; state unchanged.

Source files
------------

// File: rtl/kamikaze_mem_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store.
// One outstanding transaction; LSU has priority, bounded by a streak counter.
module kamikaze_mem_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] MaxStreak = 4'(MAX_LS_STREAK);

  state_e      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        accept_s;
  logic        gnt_ls_s;
  logic        gnt_if_s;

  // Accept opportunity and arbitration; gated by reset so no grant is lost.
  always_comb begin
    accept_s = 1'b0;
    gnt_ls_s = 1'b0;
    gnt_if_s = 1'b0;
    if (rst_i && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && mem_rvalid_i))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (accept_s) begin
      if (ls_req_i && if_req_i) begin
        if (streak_q == MaxStreak) begin
          gnt_if_s = 1'b1;
        end else begin
          gnt_ls_s = 1'b1;
        end
      end else if (ls_req_i) begin
        gnt_ls_s = 1'b1;
      end else if (if_req_i) begin
        gnt_if_s = 1'b1;
      end else begin
        gnt_ls_s = 1'b0;
      end
    end else begin
      gnt_if_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_ls_s || gnt_if_s) state_d = ST_REQ;
        else                      state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (mem_gnt_i) state_d = ST_RESP;
        else           state_d = ST_REQ;
      end
      ST_RESP: begin
        if (!mem_rvalid_i)            state_d = ST_RESP;
        else if (gnt_ls_s || gnt_if_s) state_d = ST_REQ;
        else                          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request stage, owner flag and streak counter next values.
  always_comb begin
    owner_ls_d  = owner_ls_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt_ls_s) begin
      owner_ls_d  = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = ls_we_i;
      mem_be_d    = ls_be_i;
      mem_addr_d  = ls_addr_i;
      mem_wdata_d = ls_wdata_i;
      if (!if_req_i)                streak_d = 4'd0;
      else if (streak_q < MaxStreak) streak_d = streak_q + 4'd1;
      else                          streak_d = streak_q;
    end else if (gnt_if_s) begin
      owner_ls_d  = 1'b0;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_be_d    = 4'hF;
      mem_addr_d  = if_addr_i;
      mem_wdata_d = 32'h0000_0000;
      streak_d    = 4'd0;
    end else if ((state_q == ST_REQ) && mem_gnt_i) begin
      mem_req_d = 1'b0;
    end else begin
      mem_req_d = mem_req_q;
    end
  end

  // Output decode; responses outside RESP are dropped.
  always_comb begin
    if_gnt_o    = gnt_if_s;
    ls_gnt_o    = gnt_ls_s;
    if_rdata_o  = mem_rdata_i;
    ls_rdata_o  = mem_rdata_i;
    busy_o      = (state_q != ST_IDLE);
    if (rst_i && (state_q == ST_RESP) && mem_rvalid_i) begin
      if_rvalid_o = !owner_ls_q;
      ls_rvalid_o = owner_ls_q;
    end else begin
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
    end
  end

  // State and request-stage registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      owner_ls_q  <= 1'b0;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_kamikaze_mem_arbiter.sv
// Directed bench for kamikaze_mem_arbiter: inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_kamikaze_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  kamikaze_mem_arbiter #(.MAX_LS_STREAK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o} !== 71'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wdata=%h busy=%b, expected all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o);
    end
    checks++;
    if ({if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 0000", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o});
    end
    rst_i = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
    #1;
    checks++;
    if ({if_gnt_o, ls_gnt_o} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt: got if/ls=%b expected 10", {if_gnt_o, ls_gnt_o});
    end
    @(negedge clk_i);
    if_req_i = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
      errors++;
      $display("FAIL fetch_mem_fields: got req=%b we=%b be=%h addr=%h wdata=%h, expected 1 0 F 00000100 00000000",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    checks++;
    if ({if_rvalid_o, ls_rvalid_o, busy_o} !== 3'b001) begin
      errors++; $display("FAIL fetch_req_phase: got rv_if/rv_ls/busy=%b expected 001", {if_rvalid_o, ls_rvalid_o, busy_o});
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o, mem_req_o, if_rdata_o} !== {3'b100, 32'h13}) begin
      errors++;
      $display("FAIL fetch_resp: got rv_if=%b rv_ls=%b req=%b rdata=%h expected 1 0 0 00000013",
               if_rvalid_o, ls_rvalid_o, mem_req_o, if_rdata_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL fetch_idle: got busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_store();
    @(negedge clk_i);
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011;
    ls_addr_i = 32'h2000; ls_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1'b0;
    #1;
    checks++;
    if ({if_gnt_o, ls_gnt_o} !== 2'b01) begin
      errors++; $display("FAIL store_gnt: got if/ls=%b expected 01", {if_gnt_o, ls_gnt_o});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      ls_req_i = 1'b0; ls_wdata_i = 32'h0; ls_addr_i = 32'h0;
      mem_gnt_i = (c == 2);
      #1;
      checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, if_gnt_o} !==
          {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF, 1'b0}) begin
        errors++;
        $display("FAIL store_hold[%0d]: got req=%b we=%b be=%h addr=%h wdata=%h ifgnt=%b, expected 1 1 3 00002000 deadbeef 0",
                 c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, if_gnt_o);
      end
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    #1;
    checks++;
    if ({ls_rvalid_o, if_rvalid_o, mem_req_o} !== 3'b100) begin
      errors++; $display("FAIL store_resp: got rv_ls/rv_if/req=%b expected 100", {ls_rvalid_o, if_rvalid_o, mem_req_o});
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_if;
    bit   seen;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h400;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h3000;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5;
    for (int g = 0; g < 10; g++) begin
      exp_if = ((g % 5) == 4);
      seen = 1'b0;
      for (int w = 0; w < 4 && !seen; w++) begin
        if (w != 0 || g != 0) @(negedge clk_i);
        #1;
        seen = if_gnt_o || ls_gnt_o;
      end
      checks++;
      if (!seen || {if_gnt_o, ls_gnt_o} !== {exp_if, !exp_if}) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got if/ls=%b expected %b", g, {if_gnt_o, ls_gnt_o}, {exp_if, !exp_if});
      end
    end
    @(negedge clk_i);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL contention_drain: got busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h40; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    ls_req_i = 1'b0;
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
    ls_req_i = 1'b1; ls_addr_i = 32'h44;
    #1;
    checks++;
    if ({ls_rvalid_o, ls_gnt_o, if_gnt_o, ls_rdata_o} !== {3'b110, 32'hCAFE0001}) begin
      errors++;
      $display("FAIL b2b_same_cycle: got rv=%b gnt=%b ifgnt=%b rdata=%h expected 1 1 0 cafe0001",
               ls_rvalid_o, ls_gnt_o, if_gnt_o, ls_rdata_o);
    end
    @(negedge clk_i);
    ls_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o, busy_o} !== {1'b1, 32'h44, 1'b1}) begin
      errors++;
      $display("FAIL b2b_no_gap: got req=%b addr=%h busy=%b expected 1 00000044 1", mem_req_o, mem_addr_o, busy_o);
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h300; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    if_req_i = 1'b0;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
    #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_rvalid: got rv_if/rv_ls/busy=%b expected 000", {if_rvalid_o, ls_rvalid_o, busy_o});
    end
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 70'd0) begin
      errors++;
      $display("FAIL rst_mid_mem: got req=%b we=%b be=%h addr=%h wdata=%h expected all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_stray_response();
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL stray_idle: got rv_if/rv_ls/busy=%b expected 000", {if_rvalid_o, ls_rvalid_o, busy_o});
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h80; ls_be_i = 4'hF;
    @(negedge clk_i);
    ls_req_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o, mem_req_o} !== 3'b001) begin
      errors++; $display("FAIL stray_req: got rv_if/rv_ls/req=%b expected 001", {if_rvalid_o, ls_rvalid_o, mem_req_o});
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({mem_req_o, busy_o, mem_addr_o} !== {2'b11, 32'h80}) begin
      errors++; $display("FAIL stray_state_kept: got req=%b busy=%b addr=%h expected 1 1 00000080", mem_req_o, busy_o, mem_addr_o);
    end
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    checks++;
    if (ls_rvalid_o !== 1'b1) begin
      errors++; $display("FAIL stray_final_resp: got rv_ls=%b expected 1", ls_rvalid_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'h0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_back_to_back();
    test_reset_mid_op();
    test_stray_response();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
